// File: rtl/pll_rst_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   - FSM state encodings (plain 3-bit constants so older tools and
//     hand-written checkers can compare against raw values)
//   - Output field widths for the retry count and the lock-loss count
//   - max_of(): sizes the shared sequencing counter
package pll_pkg;

  localparam int RETRY_W    = 4;
  localparam int LOSS_CNT_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST_PLL   = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_FILTER    = 3'd2;
  localparam state_t ST_RELEASE   = 3'd3;
  localparam state_t ST_RUN       = 3'd4;
  localparam state_t ST_FAIL      = 3'd5;

  function automatic int max_of(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_rst_sequencer_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser with synchronous active-low reset.
//   clk   in   destination clock
//   rst_n in   synchronous reset, active-low; clears both flops to 0
//   d     in   asynchronous input
//   q     out  synchronised output, 2 cycles after d is first sampled
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/pll_rst_sequencer.sv
// pll_rst_sequencer: supervises a PLL wrapper and sequences per-domain resets.
// Pulses the PLL reset, waits for lock with timeout/retry, debounces lock,
// then releases domain resets one by one, STAGGER cycles apart. Loss of lock
// in RELEASE/RUN tears everything down and restarts from a PLL reset.
//   clk           in   free-running reference clock (PLL input clock)
//   rst_n         in   synchronous reset, active-low
//   pll_lock      in   raw PLL lock, asynchronous to clk
//   pll_rst       out  PLL reset, active-high
//   domain_rst_n  out  per-domain reset, active-low, bit 0 released first
//   ready         out  high in RUN
//   fail          out  high in FAIL (sticky until rst_n)
//   retry_cnt     out  failed lock attempts in the current sequence
//   lock_lost     out  one-cycle pulse when lock drops in RELEASE/RUN
// Optional (`define LOCK_LOSS_COUNT_EN):
//   lock_loss_clr in   clears lock_loss_cnt next cycle (beats increment)
//   lock_loss_cnt out  saturating count of lock_lost pulses
module pll_rst_sequencer
  import pll_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int PLL_RST_CYCLES = 64,
  parameter int LOCK_TIMEOUT   = 500000,
  parameter int LOCK_FILT      = 1024,
  parameter int STAGGER        = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_lock,
`ifdef LOCK_LOSS_COUNT_EN
  input  logic                   lock_loss_clr,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt,
`endif
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic                   fail,
  output logic [RETRY_W-1:0]     retry_cnt,
  output logic                   lock_lost
);

  // One counter is shared by every timed state; only one runs at a time.
  localparam int CNT_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                  max_of(LOCK_FILT, STAGGER));
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             loss_evt;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign loss_evt = ((state == ST_RELEASE) || (state == ST_RUN)) && !lock_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_RST_PLL;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      domain_rst_n <= '0;
      ready        <= 1'b0;
      fail         <= 1'b0;
      retry_cnt    <= '0;
      lock_lost    <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      case (state)
        ST_RST_PLL: begin
          if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state   <= ST_WAIT_LOCK;
            pll_rst <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested before the timeout so a coincident rise wins.
          if (lock_s) begin
            state <= ST_FILTER;
            cnt   <= '0;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            retry_cnt <= retry_cnt + 1'b1;
            cnt       <= '0;
            if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              state   <= ST_RST_PLL;
              pll_rst <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FILTER: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CNT_W'(LOCK_FILT - 1)) begin
            state        <= ST_RELEASE;
            cnt          <= '0;
            domain_rst_n <= NUM_DOMAINS'(1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (loss_evt) begin
            state        <= ST_RST_PLL;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            lock_lost    <= 1'b1;
          end else if (state == ST_RELEASE) begin
            if (domain_rst_n[NUM_DOMAINS-1]) begin
              state     <= ST_RUN;
              ready     <= 1'b1;
              retry_cnt <= '0;
            end else if (cnt == CNT_W'(STAGGER - 1)) begin
              // Shift in a 1: the next domain up comes out of reset.
              domain_rst_n <= NUM_DOMAINS'({domain_rst_n, 1'b1});
              cnt          <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_FAIL: ;  // sticky; only rst_n leaves
        default: begin
          state        <= ST_RST_PLL;
          cnt          <= '0;
          pll_rst      <= 1'b1;
          domain_rst_n <= '0;
          ready        <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                           lock_loss_cnt <= '0;
    else if (lock_loss_clr)               lock_loss_cnt <= '0;
    else if (loss_evt && !(&lock_loss_cnt)) lock_loss_cnt <= lock_loss_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pll_rst_sequencer.sv
module tb_pll_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_rst;
  logic [2:0] domain_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic       lock_lost;
`ifdef LOCK_LOSS_COUNT_EN
  logic        lock_loss_clr;
  logic [15:0] lock_loss_cnt;
`endif

  always #5 clk = ~clk;

  pll_rst_sequencer #(
    .NUM_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .LOCK_FILT(8), .STAGGER(3), .MAX_RETRY(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
`ifdef LOCK_LOSS_COUNT_EN
    .lock_loss_clr(lock_loss_clr),
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .pll_rst      (pll_rst),
    .domain_rst_n (domain_rst_n),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_lost    (lock_lost)
  );

  // One record: at relative cycle 'at' drive lock/clr; optionally expect outputs
  // as seen during that cycle (after edge E_at). E0 is the first edge with rst_n=1.
  typedef struct {
    int          sc;
    int          at;
    logic        lock;
    logic        clr;
    logic        chk;
    logic        pr;
    logic [2:0]  dom;
    logic        rdy;
    logic        fl;
    logic [3:0]  rc;
    logic        ll;
    logic        lc_chk;
    logic [15:0] lcnt;
    string       name;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(int sc, int at, logic lk, logic chk, logic pr,
                              logic [2:0] dom, logic rdy, logic fl,
                              logic [3:0] rc, logic ll, string nm);
    vec_t v;
    v.sc = sc; v.at = at; v.lock = lk; v.clr = 1'b0; v.chk = chk;
    v.pr = pr; v.dom = dom; v.rdy = rdy; v.fl = fl; v.rc = rc; v.ll = ll;
    v.lc_chk = 1'b0; v.lcnt = '0; v.name = nm;
    return v;
  endfunction

  // Scoreboard consumer: compares the head entry in the cycle it targets.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].at == cyc - base) begin
        vec_t e;
        e = sb.pop_front();
        checks++;
        if ({pll_rst, domain_rst_n, ready, fail, retry_cnt, lock_lost} !==
            {e.pr, e.dom, e.rdy, e.fl, e.rc, e.ll}) begin
          failures++;
          $display("FAIL %s @%0d: got pr=%b dom=%b rdy=%b fail=%b rc=%0d ll=%b, exp pr=%b dom=%b rdy=%b fail=%b rc=%0d ll=%b",
                   e.name, e.at, pll_rst, domain_rst_n, ready, fail, retry_cnt, lock_lost,
                   e.pr, e.dom, e.rdy, e.fl, e.rc, e.ll);
        end
`ifdef LOCK_LOSS_COUNT_EN
        if (e.lc_chk) begin
          checks++;
          if (lock_loss_cnt !== e.lcnt) begin
            failures++;
            $display("FAIL %s_cnt @%0d: got %0d exp %0d", e.name, e.at, lock_loss_cnt, e.lcnt);
          end
        end
`endif
      end else if (sb[0].at < cyc - base) begin
        vec_t e;
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL %s: check cycle %0d missed (now %0d)", e.name, e.at, cyc - base);
      end
    end
  end

  task automatic step_to(input int k);
    while (cyc - base < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input vec_t v);
    step_to(v.at);
    pll_lock = v.lock;
`ifdef LOCK_LOSS_COUNT_EN
    lock_loss_clr = v.clr;
`endif
    if (v.chk) sb.push_back(v);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d checks left, exp 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    rst_n = 1'b0;
    pll_lock = 1'b0;
`ifdef LOCK_LOSS_COUNT_EN
    lock_loss_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = cyc + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // sc 0: nominal bring-up, lock 10 cycles after pll_rst falls
    tbl.push_back(mk(0, -1, 0, 1, 1, 3'b000, 0, 0, 0, 0, "nom_reset"));
    tbl.push_back(mk(0,  2, 0, 1, 1, 3'b000, 0, 0, 0, 0, "nom_rst_last"));
    tbl.push_back(mk(0,  3, 0, 1, 0, 3'b000, 0, 0, 0, 0, "nom_rst_fall"));
    tbl.push_back(mk(0, 13, 1, 1, 0, 3'b000, 0, 0, 0, 0, "nom_lock_rise"));
    tbl.push_back(mk(0, 23, 1, 1, 0, 3'b000, 0, 0, 0, 0, "nom_filter_end"));
    tbl.push_back(mk(0, 24, 1, 1, 0, 3'b001, 0, 0, 0, 0, "nom_dom0"));
    tbl.push_back(mk(0, 26, 1, 1, 0, 3'b001, 0, 0, 0, 0, "nom_dom0_hold"));
    tbl.push_back(mk(0, 27, 1, 1, 0, 3'b011, 0, 0, 0, 0, "nom_dom1"));
    tbl.push_back(mk(0, 30, 1, 1, 0, 3'b111, 0, 0, 0, 0, "nom_dom2"));
    tbl.push_back(mk(0, 31, 1, 1, 0, 3'b111, 1, 0, 0, 0, "nom_ready"));
    // sc 1: glitchy lock, filter restarts after the 1-cycle drop
    tbl.push_back(mk(1, -1, 0, 1, 1, 3'b000, 0, 0, 0, 0, "gl_reset"));
    tbl.push_back(mk(1,  5, 1, 1, 0, 3'b000, 0, 0, 0, 0, "gl_rise1"));
    tbl.push_back(mk(1, 10, 0, 1, 0, 3'b000, 0, 0, 0, 0, "gl_drop"));
    tbl.push_back(mk(1, 11, 1, 1, 0, 3'b000, 0, 0, 0, 0, "gl_rise2"));
    tbl.push_back(mk(1, 16, 1, 1, 0, 3'b000, 0, 0, 0, 0, "gl_no_early"));
    tbl.push_back(mk(1, 21, 1, 1, 0, 3'b000, 0, 0, 0, 0, "gl_pre_rel"));
    tbl.push_back(mk(1, 22, 1, 1, 0, 3'b001, 0, 0, 0, 0, "gl_dom0"));
    tbl.push_back(mk(1, 25, 1, 1, 0, 3'b011, 0, 0, 0, 0, "gl_dom1"));
    tbl.push_back(mk(1, 28, 1, 1, 0, 3'b111, 0, 0, 0, 0, "gl_dom2"));
    tbl.push_back(mk(1, 29, 1, 1, 0, 3'b111, 1, 0, 0, 0, "gl_ready"));
    // sc 2: no lock -> two timeouts -> sticky FAIL
    tbl.push_back(mk(2, -1, 0, 1, 1, 3'b000, 0, 0, 0, 0, "to_reset"));
    tbl.push_back(mk(2,  3, 0, 1, 0, 3'b000, 0, 0, 0, 0, "to_wait"));
    tbl.push_back(mk(2, 22, 0, 1, 0, 3'b000, 0, 0, 0, 0, "to_pre_tmo1"));
    tbl.push_back(mk(2, 23, 0, 1, 1, 3'b000, 0, 0, 1, 0, "to_tmo1"));
    tbl.push_back(mk(2, 26, 0, 1, 1, 3'b000, 0, 0, 1, 0, "to_rst2_last"));
    tbl.push_back(mk(2, 27, 0, 1, 0, 3'b000, 0, 0, 1, 0, "to_rst2_fall"));
    tbl.push_back(mk(2, 46, 0, 1, 0, 3'b000, 0, 0, 1, 0, "to_pre_tmo2"));
    tbl.push_back(mk(2, 47, 0, 1, 0, 3'b000, 0, 1, 2, 0, "to_fail"));
    tbl.push_back(mk(2, 50, 1, 1, 0, 3'b000, 0, 1, 2, 0, "to_fail_lock"));
    tbl.push_back(mk(2, 70, 1, 1, 0, 3'b000, 0, 1, 2, 0, "to_fail_sticky"));
    // sc 3: lock loss in RUN and full recovery
    tbl.push_back(mk(3, -1, 0, 1, 1, 3'b000, 0, 0, 0, 0, "ll_reset"));
    tbl.push_back(mk(3, 13, 1, 0, 0, 3'b000, 0, 0, 0, 0, "ll_rise"));
    tbl.push_back(mk(3, 31, 1, 1, 0, 3'b111, 1, 0, 0, 0, "ll_ready"));
    tbl.push_back(mk(3, 35, 0, 1, 0, 3'b111, 1, 0, 0, 0, "ll_drop"));
    tbl.push_back(mk(3, 36, 1, 0, 0, 3'b111, 1, 0, 0, 0, "ll_back"));
    tbl.push_back(mk(3, 37, 1, 1, 0, 3'b111, 1, 0, 0, 0, "ll_still_run"));
    tbl.push_back(mk(3, 38, 1, 1, 1, 3'b000, 0, 0, 0, 1, "ll_pulse"));
    tbl.push_back(mk(3, 39, 1, 1, 1, 3'b000, 0, 0, 0, 0, "ll_pulse_end"));
    tbl.push_back(mk(3, 41, 1, 1, 1, 3'b000, 0, 0, 0, 0, "ll_rst_last"));
    tbl.push_back(mk(3, 42, 1, 1, 0, 3'b000, 0, 0, 0, 0, "ll_rst_fall"));
    tbl.push_back(mk(3, 51, 1, 1, 0, 3'b001, 0, 0, 0, 0, "ll_rec_dom0"));
    tbl.push_back(mk(3, 57, 1, 1, 0, 3'b111, 0, 0, 0, 0, "ll_rec_dom2"));
    tbl.push_back(mk(3, 58, 1, 1, 0, 3'b111, 1, 0, 0, 0, "ll_rec_ready"));

    rst_n = 1'b0;
    pll_lock = 1'b0;
`ifdef LOCK_LOSS_COUNT_EN
    lock_loss_clr = 1'b0;
`endif

    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int i = 0; i < tbl.size(); i++)
        if (tbl[i].sc == s) apply(tbl[i]);
    end

    // rst_n asserted while domain_rst_n == 011
    do_reset();
    apply(mk(4, 13, 1, 0, 0, 3'b000, 0, 0, 0, 0, "mr_rise"));
    apply(mk(4, 28, 1, 1, 0, 3'b011, 0, 0, 0, 0, "mr_mid_release"));
    rst_n = 1'b0;
    apply(mk(4, 29, 1, 1, 1, 3'b000, 0, 0, 0, 0, "mr_reset_vals"));
    apply(mk(4, 31, 1, 1, 1, 3'b000, 0, 0, 0, 0, "mr_reset_hold"));

`ifdef LOCK_LOSS_COUNT_EN
    // Three losses count to 3; clear coinciding with a fourth wins.
    do_reset();
    v = mk(5, -1, 0, 1, 1, 3'b000, 0, 0, 0, 0, "lc_reset"); v.lc_chk = 1; v.lcnt = 0; apply(v);
    apply(mk(5, 13, 1, 0, 0, 3'b000, 0, 0, 0, 0, "lc_rise"));
    apply(mk(5, 35, 0, 0, 0, 3'b000, 0, 0, 0, 0, "lc_drop1"));
    apply(mk(5, 36, 1, 0, 0, 3'b000, 0, 0, 0, 0, "lc_back1"));
    v = mk(5, 38, 1, 1, 1, 3'b000, 0, 0, 0, 1, "lc_loss1"); v.lc_chk = 1; v.lcnt = 1; apply(v);
    apply(mk(5, 60, 0, 0, 0, 3'b000, 0, 0, 0, 0, "lc_drop2"));
    apply(mk(5, 61, 1, 0, 0, 3'b000, 0, 0, 0, 0, "lc_back2"));
    apply(mk(5, 85, 0, 0, 0, 3'b000, 0, 0, 0, 0, "lc_drop3"));
    apply(mk(5, 86, 1, 0, 0, 3'b000, 0, 0, 0, 0, "lc_back3"));
    v = mk(5, 90, 1, 1, 1, 3'b000, 0, 0, 0, 0, "lc_three"); v.lc_chk = 1; v.lcnt = 3; apply(v);
    apply(mk(5, 110, 0, 0, 0, 3'b000, 0, 0, 0, 0, "lc_drop4"));
    v = mk(5, 112, 1, 1, 0, 3'b111, 1, 0, 0, 0, "lc_pre4"); v.clr = 1; v.lc_chk = 1; v.lcnt = 3; apply(v);
    v = mk(5, 113, 1, 1, 1, 3'b000, 0, 0, 0, 1, "lc_clr_wins"); v.lc_chk = 1; v.lcnt = 0; apply(v);
    v = mk(5, 115, 1, 1, 1, 3'b000, 0, 0, 0, 0, "lc_cleared"); v.lc_chk = 1; v.lcnt = 0; apply(v);
`endif

    drain();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
